skip_squash: RTL and testbench

//   Consumes the skip decision from the execute-stage skip calculator and the

---
 rtl/ez8_pkg.sv | 17 +
 rtl/squash_counter.sv | 49 ++++
 rtl/skip_squash.sv | 176 +++++++++++++++++
 tb/tb_skip_squash.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ez8_pkg.sv
// ---------------------------------------------------------------------------
// ez8_pkg
//   Shared constants for the execute-stage squash logic.
//   - Squash FSM state encoding (IDLE / SKIP / FLUSH), 2-bit.
//   - Default squash depth, flush length and counter width.
// ---------------------------------------------------------------------------
package ez8_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int unsigned DEF_SKIP_DEPTH   = 1;
    localparam int unsigned DEF_FLUSH_CYCLES = 1;
    localparam int unsigned DEF_CNT_W        = 3;

endpackage

// File: rtl/squash_counter.sv
// ---------------------------------------------------------------------------
// squash_counter
//   Loadable down-counter used by skip_squash to track how many issues
//   (SKIP) or unstalled cycles (FLUSH) remain to be squashed.
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous reset, active-high (clears count)
//   load_i      in   load load_val_i (has priority over dec_i)
//   load_val_i  in   value to load
//   dec_i       in   decrement enable (holds at zero)
//   cnt_o       out  current count
//   zero_o      out  count is zero
// ---------------------------------------------------------------------------
module squash_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/skip_squash.sv
// ---------------------------------------------------------------------------
// skip_squash
//   Squashes instructions issued behind a taken skip or a taken jump.
//   Sits between execute and the decode->execute issue point.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | nothing pending; issues pass through
//   SKIP  | kill the next cnt issued instructions (bubbles do not count)
//   FLUSH | kill any issue for the next cnt unstalled cycles after a jump
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active-high
//   stall        in   pipeline hold (no issue, no execute retire)
//   id_valid     in   valid instruction presented for issue
//   ex_valid     in   valid instruction in execute
//   ex_skip      in   skip condition true for the execute instruction
//   ex_jump      in   jump/call/ret taken by the execute instruction
//   kill         out  squash the issuing instruction (combinational)
//   flush_front  out  clear fetch/decode valid bits (combinational pulse)
//   ex_squashed  out  execute instruction was killed at issue (registered)
//   busy         out  state != IDLE (registered)
//   skip_count   out  16-bit taken-skip count (only with SKIP_STATS_EN)
//
// Build option: define SKIP_STATS_EN to add the skip_count port/counter.
// ---------------------------------------------------------------------------
module skip_squash
    import ez8_pkg::*;
#(
    parameter int unsigned SKIP_DEPTH   = DEF_SKIP_DEPTH,
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid,
    input  logic        ex_valid,
    input  logic        ex_skip,
    input  logic        ex_jump,
    output logic        kill,
    output logic        flush_front,
    output logic        ex_squashed,
    output logic        busy
`ifdef SKIP_STATS_EN
    ,
    output logic [15:0] skip_count
`endif
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             ex_squashed_q;
    logic             ex_squashed_d;
    logic             busy_q;

    logic             issue;
    logic             ex_live;
    logic             skip_ev;
    logic             jump_ev;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_last;

    assign issue   = id_valid & ~stall;
    // A squashed instruction must never trigger a redirect of its own.
    assign ex_live = ex_valid & ~ex_squashed_q & ~stall;
    assign jump_ev = ex_live & ex_jump;
    assign skip_ev = ex_live & ex_skip & ~ex_jump;

    assign cnt_last = (cnt == CNT_W'(1));

    squash_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (jump_ev) begin
                    state_d      = ST_FLUSH;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(FLUSH_CYCLES);
                end else if (skip_ev) begin
                    state_d      = ST_SKIP;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(SKIP_DEPTH);
                end
            end
            ST_SKIP: begin
                // A jump from the still-live instruction ahead of the skipped
                // ones overrides whatever skip depth remains.
                if (jump_ev) begin
                    state_d      = ST_FLUSH;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(FLUSH_CYCLES);
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else if (issue) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (jump_ev) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(FLUSH_CYCLES);
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else if (!stall) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Issue is already gated by !stall, so the stalled case only needs to hold.
    assign ex_squashed_d = stall ? ex_squashed_q : (issue & kill);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ex_squashed_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ex_squashed_q <= ex_squashed_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign kill        = id_valid & (state_q != ST_IDLE);
    assign flush_front = jump_ev;
    assign ex_squashed = ex_squashed_q;
    assign busy        = busy_q;

`ifdef SKIP_STATS_EN
    logic [15:0] skip_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_count_q <= 16'd0;
        end else if (skip_ev) begin
            skip_count_q <= skip_count_q + 16'd1;
        end
    end

    assign skip_count = skip_count_q;
`endif

endmodule

// File: tb/tb_skip_squash.sv
module tb_skip_squash;

    localparam int SD = 2;
    localparam int FC = 3;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic id_valid;
    logic ex_valid;
    logic ex_skip;
    logic ex_jump;
    logic kill;
    logic flush_front;
    logic ex_squashed;
    logic busy;
`ifdef SKIP_STATS_EN
    logic [15:0] skip_count;
`endif

    skip_squash #(
        .SKIP_DEPTH   (SD),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .id_valid    (id_valid),
        .ex_valid    (ex_valid),
        .ex_skip     (ex_skip),
        .ex_jump     (ex_jump),
        .kill        (kill),
        .flush_front (flush_front),
        .ex_squashed (ex_squashed),
        .busy        (busy)
`ifdef SKIP_STATS_EN
        ,
        .skip_count  (skip_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining issues to kill after a skip, remaining
    // unstalled cycles to kill after a jump, and whether the execute
    // instruction was killed when it issued.
    int          skip_left = 0;
    int          flush_left = 0;
    bit          sq_m = 1'b0;
    int unsigned skips_m = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        skip_left  = 0;
        flush_left = 0;
        sq_m       = 1'b0;
        skips_m    = 0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, then
    // advance the model to what the next clock edge should produce.
    task automatic step(input bit st, input bit iv, input bit ev, input bit es, input bit ej);
        bit issue_m, live_m, jev_m, sev_m, kill_m;
        @(negedge clk);
        stall    = st;
        id_valid = iv;
        ex_valid = ev;
        ex_skip  = es;
        ex_jump  = ej;
        #1;
        issue_m = iv && !st;
        live_m  = ev && !sq_m && !st;
        jev_m   = live_m && ej;
        sev_m   = live_m && es && !ej;
        kill_m  = iv && ((skip_left > 0) || (flush_left > 0));
        check_val("kill",        32'(kill),        32'(kill_m));
        check_val("flush_front", 32'(flush_front), 32'(jev_m));
        check_val("ex_squashed", 32'(ex_squashed), 32'(sq_m));
        check_val("busy",        32'(busy),        32'((skip_left > 0) || (flush_left > 0)));
`ifdef SKIP_STATS_EN
        check_val("skip_count",  32'(skip_count),  32'(skips_m & 32'hFFFF));
`endif
        if (jev_m) begin
            flush_left = FC;
            skip_left  = 0;
        end else if (flush_left > 0) begin
            if (!st) flush_left--;
        end else if (skip_left > 0) begin
            if (issue_m) skip_left--;
        end else if (sev_m) begin
            skip_left = SD;
        end
        if (!st) sq_m = issue_m && kill_m;
        if (sev_m) skips_m++;
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        id_valid = 1'b1;
        ex_valid = 1'b0;
        ex_skip  = 1'b0;
        ex_jump  = 1'b0;
        #2;
        check_val("rst_kill",        32'(kill),        32'd0);
        check_val("rst_flush_front", 32'(flush_front), 32'd0);
        check_val("rst_ex_squashed", 32'(ex_squashed), 32'd0);
        check_val("rst_busy",        32'(busy),        32'd0);
`ifdef SKIP_STATS_EN
        check_val("rst_skip_count",  32'(skip_count),  32'd0);
`endif
        model_clear();
        @(negedge clk);
        reset = 1'b0;

        // Single skip with back-to-back issue.
        step(0, 1, 1, 1, 0);
        repeat (4) step(0, 1, 0, 0, 0);
        // Skip across a bubble.
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0);
        // Stall during skip.
        step(0, 1, 1, 1, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0);
        // Jump flush.
        step(0, 1, 1, 0, 1);
        repeat (5) step(0, 1, 0, 0, 0);
        // Skip then jump from the unkilled next instruction; then a squashed
        // instruction presenting ex_skip.
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        repeat (5) step(0, 1, 0, 0, 0);
        // Jump while already flushing reloads the flush length.
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0);

        // Reset mid-SKIP (cnt = SD = 2): squashing stops immediately.
        step(0, 0, 1, 1, 0);
        @(negedge clk);
        stall    = 1'b0;
        id_valid = 1'b1;
        ex_valid = 1'b0;
        #1;
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_kill",        32'(kill),        32'd0);
        check_val("mid_rst_busy",        32'(busy),        32'd0);
        check_val("mid_rst_ex_squashed", 32'(ex_squashed), 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(0, 1, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
